// File: rtl/vu_meter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : vu_meter_pkg                                               |
// | Description : Shared types and widths for the VU meter PWM link.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package vu_meter_pkg;

  // Published duty width: one LSB per step of the 128-step VU PWM
  localparam int VU_DUTY_W = 7;
  // Internal high-time / period counter width
  localparam int VU_CNT_W  = 10;

  // Per-channel capture state
  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_HIGH = 2'd1,
    CAP_LOW  = 2'd2
  } cap_state_t;

endpackage : vu_meter_pkg
`default_nettype wire

// File: rtl/vu_pwm_capture_chan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vu_pwm_capture_chan                                        |
// | Description : One VU PWM capture channel: 2-flop synchronizer, edge      |
// |               detect, high/period measurement FSM, stuck-line timeout    |
// |               and optional peak-hold with slow decay.                    |
// |               Optional feature macro: VU_PWM_CAPTURE_PEAK_HOLD_EN        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module vu_pwm_capture_chan
  import vu_meter_pkg::*;
#(
  parameter int DUTY_W    = VU_DUTY_W,
  parameter int CNT_W     = VU_CNT_W,
  parameter int TIMEOUT   = 1023,
  parameter int DECAY_DIV = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty,
  output logic              valid,
  output logic              stuck,
  output logic [DUTY_W-1:0] peak
);

  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_timeout  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_duty_lim = CNT_W'((1 << DUTY_W) - 1);

  // r_sync[0..1] are the metastability flops, r_sync[2] the edge-detect delay
  logic [2:0]        r_sync;
  logic              w_rise;
  logic              w_fall;

  cap_state_t        r_state;
  cap_state_t        w_next_state;
  logic [CNT_W-1:0]  r_hi_cnt;
  logic [CNT_W-1:0]  r_per_cnt;
  logic [CNT_W-1:0]  w_hi_next;
  logic [CNT_W-1:0]  w_per_next;
  logic              w_pub;
  logic [DUTY_W-1:0] w_pub_duty;
  logic              w_stuck_next;
  logic [DUTY_W-1:0] r_duty;
  logic              r_valid;
  logic              r_stuck;

  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
    return (v == c_cnt_max) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [DUTY_W-1:0] f_sat_duty(input logic [CNT_W-1:0] v);
    return (v > c_duty_lim) ? {DUTY_W{1'b1}} : v[DUTY_W-1:0];
  endfunction

  // Synchronizer chain keeps running regardless of enable so re-enable sees no false edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 3'b000;
    else        r_sync <= {r_sync[1:0], pwm_in};
  end

  assign w_rise = r_sync[1] & ~r_sync[2];
  assign w_fall = ~r_sync[1] & r_sync[2];

  // State, counters and published outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= CAP_IDLE;
      r_hi_cnt  <= '0;
      r_per_cnt <= '0;
      r_duty    <= '0;
      r_valid   <= 1'b0;
      r_stuck   <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_hi_cnt  <= w_hi_next;
      r_per_cnt <= w_per_next;
      r_valid   <= w_pub;
      r_stuck   <= w_stuck_next;
      if (w_pub) r_duty <= w_pub_duty;
    end
  end

  // Next-state, counter and publish decode; a rising edge beats a same-clk timeout
  always_comb begin
    w_next_state = r_state;
    w_hi_next    = r_hi_cnt;
    w_per_next   = r_per_cnt;
    w_pub        = 1'b0;
    w_pub_duty   = '0;
    w_stuck_next = r_stuck;
    if (!enable) begin
      w_next_state = CAP_IDLE;
      w_hi_next    = '0;
      w_per_next   = '0;
    end else begin
      case (r_state)
        CAP_IDLE: begin
          if (w_rise) begin
            w_next_state = CAP_HIGH;
            w_hi_next    = CNT_W'(1);
            w_per_next   = CNT_W'(1);
            w_stuck_next = 1'b0;
          end
        end
        CAP_HIGH, CAP_LOW: begin
          if (w_rise) begin
            w_pub        = 1'b1;
            w_pub_duty   = f_sat_duty(r_hi_cnt);
            w_next_state = CAP_HIGH;
            w_hi_next    = CNT_W'(1);
            w_per_next   = CNT_W'(1);
            w_stuck_next = 1'b0;
          end else if (r_per_cnt == c_timeout) begin
            w_pub        = 1'b1;
            w_pub_duty   = {DUTY_W{r_sync[1]}};
            w_stuck_next = 1'b1;
            w_next_state = CAP_IDLE;
            w_hi_next    = '0;
            w_per_next   = '0;
          end else begin
            w_per_next = f_sat_inc(r_per_cnt);
            if (r_state == CAP_HIGH) begin
              if (w_fall) w_next_state = CAP_LOW;
              else        w_hi_next    = f_sat_inc(r_hi_cnt);
            end
          end
        end
        default: begin
          w_next_state = CAP_IDLE;
          w_hi_next    = '0;
          w_per_next   = '0;
        end
      endcase
    end
  end

  assign duty  = r_duty;
  assign valid = r_valid;
  assign stuck = r_stuck;

`ifdef VU_PWM_CAPTURE_PEAK_HOLD_EN
  localparam int              c_dec_w    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [c_dec_w-1:0] c_dec_last = c_dec_w'(DECAY_DIV - 1);

  logic [DUTY_W-1:0]  r_peak;
  logic [c_dec_w-1:0] r_dec_cnt;

  // Peak tracks new maxima immediately and sags one LSB every DECAY_DIV non-raising publishes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peak    <= '0;
      r_dec_cnt <= '0;
    end else if (w_pub) begin
      if (w_pub_duty > r_peak) begin
        r_peak    <= w_pub_duty;
        r_dec_cnt <= '0;
      end else if (r_dec_cnt == c_dec_last) begin
        r_dec_cnt <= '0;
        if (r_peak != '0) r_peak <= r_peak - DUTY_W'(1);
      end else begin
        r_dec_cnt <= r_dec_cnt + c_dec_w'(1);
      end
    end
  end

  assign peak = r_peak;
`else
  assign peak = r_duty;
`endif

endmodule : vu_pwm_capture_chan
`default_nettype wire

// File: rtl/vu_pwm_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vu_pwm_capture                                             |
// | Description : Receive side of the VU meter PWM link. Measures the high   |
// |               time of each left/right PWM cycle and publishes a duty     |
// |               count, stuck-line flag and peak-hold value per channel.    |
// |               Optional feature macro: VU_PWM_CAPTURE_PEAK_HOLD_EN        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module vu_pwm_capture
  import vu_meter_pkg::*;
#(
  parameter int DUTY_W    = VU_DUTY_W,
  parameter int CNT_W     = VU_CNT_W,
  parameter int TIMEOUT   = 1023,
  parameter int DECAY_DIV = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              l_pwm_in,
  input  logic              r_pwm_in,
  output logic [DUTY_W-1:0] l_duty,
  output logic [DUTY_W-1:0] r_duty,
  output logic              l_valid,
  output logic              r_valid,
  output logic              l_stuck,
  output logic              r_stuck,
  output logic [DUTY_W-1:0] l_peak,
  output logic [DUTY_W-1:0] r_peak
);

  // Left channel
  vu_pwm_capture_chan #(
    .DUTY_W   (DUTY_W),
    .CNT_W    (CNT_W),
    .TIMEOUT  (TIMEOUT),
    .DECAY_DIV(DECAY_DIV)
  ) u_left (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(enable),
    .pwm_in(l_pwm_in),
    .duty  (l_duty),
    .valid (l_valid),
    .stuck (l_stuck),
    .peak  (l_peak)
  );

  // Right channel, fully independent of the left
  vu_pwm_capture_chan #(
    .DUTY_W   (DUTY_W),
    .CNT_W    (CNT_W),
    .TIMEOUT  (TIMEOUT),
    .DECAY_DIV(DECAY_DIV)
  ) u_right (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(enable),
    .pwm_in(r_pwm_in),
    .duty  (r_duty),
    .valid (r_valid),
    .stuck (r_stuck),
    .peak  (r_peak)
  );

endmodule : vu_pwm_capture
`default_nettype wire
